// File: rtl/mmio_timer_bank.sv
// Bank of N_CH prescaled down-counter timers on the data-RAM bus, with one level irq.
// Ports: clk, rst (async high), ram_cen/wen/flag/addr/wdata in, ram_rdata/irq/sel out. Option: TIMER_FREE_RUN_EN.
module mmio_timer_bank #(
    parameter int          N_CH      = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hE0001000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cen,
    input  logic        ram_wen,
    input  logic [3:0]  ram_flag,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic        irq,
    output logic        sel
);

    logic [CNT_W-1:0] load_q  [N_CH];
    logic [CNT_W-1:0] count_q [N_CH];
    logic [7:0]       presc_q [N_CH];
    logic [7:0]       pre_q   [N_CH];
    logic [N_CH-1:0]  en_q, per_q, ie_q, pend_q;
    logic [N_CH-1:0]  tick, expire, we_ld, we_ctl, we_st;

    logic        hit, wr, rd;
    logic [8:0]  off;
    logic [3:0]  wch;
    logic [31:0] old_ld, old_ctl, ld_new, ctl_new, rd_mux;

    assign hit = ram_cen && (ram_addr[31:9] == BASE_ADDR[31:9]);
    assign off = ram_addr[8:0];
    assign wch = off[7:4];
    assign wr  = hit && ram_wen;
    assign rd  = hit && !ram_wen;

    function automatic logic [31:0] be_merge(input logic [31:0] o,
                                             input logic [31:0] n,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Byte-enable merge only needs the addressed channel's current value.
    always_comb begin
        old_ld  = '0;
        old_ctl = '0;
        tick    = '0;
        expire  = '0;
        we_ld   = '0;
        we_ctl  = '0;
        we_st   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wch == 4'(i)) begin
                old_ld  = 32'(load_q[i]);
                old_ctl = {16'b0, presc_q[i], 5'b0, ie_q[i], per_q[i], en_q[i]};
            end
            tick[i]   = en_q[i] && (pre_q[i] == presc_q[i]);
            expire[i] = tick[i] && (count_q[i] == '0);
            we_ld[i]  = wr && !off[8] && wch == 4'(i) && off[3:2] == 2'd0;
            we_ctl[i] = wr && !off[8] && wch == 4'(i) && off[3:2] == 2'd2;
            we_st[i]  = wr && !off[8] && wch == 4'(i) && off[3:2] == 2'd3;
        end
        ld_new  = be_merge(old_ld, ram_wdata, ram_flag);
        ctl_new = be_merge(old_ctl, ram_wdata, ram_flag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            per_q  <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
                presc_q[i] <= '0;
                pre_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (en_q[i])
                    pre_q[i] <= tick[i] ? 8'd0 : pre_q[i] + 8'd1;
                if (tick[i] && !expire[i])
                    count_q[i] <= count_q[i] - CNT_W'(1);
                if (expire[i]) begin
                    if (per_q[i]) count_q[i] <= load_q[i];
                    else          en_q[i]    <= 1'b0;
                end
                // Expiry beats a same-cycle W1C.
                if (expire[i])
                    pend_q[i] <= 1'b1;
                else if (we_st[i] && ram_flag[0] && ram_wdata[0])
                    pend_q[i] <= 1'b0;
                // Bus writes come last so they override the tick for COUNT/EN.
                if (we_ld[i]) begin
                    load_q[i]  <= ld_new[CNT_W-1:0];
                    count_q[i] <= ld_new[CNT_W-1:0];
                    pre_q[i]   <= '0;
                end
                if (we_ctl[i]) begin
                    en_q[i]    <= ctl_new[0];
                    per_q[i]   <= ctl_new[1];
                    ie_q[i]    <= ctl_new[2];
                    presc_q[i] <= ctl_new[15:8];
                    if (!en_q[i] && ctl_new[0]) begin
                        count_q[i] <= load_q[i];
                        pre_q[i]   <= '0;
                    end
                end
            end
        end
    end

`ifdef TIMER_FREE_RUN_EN
    logic [31:0] frc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frc_q <= '0;
        else if (wr && off[8] && off[7:2] == 6'd1)
            frc_q <= '0;
        else
            frc_q <= frc_q + 32'd1;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (!off[8]) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wch == 4'(i)) begin
                    unique case (off[3:2])
                        2'd0: rd_mux = 32'(load_q[i]);
                        2'd1: rd_mux = 32'(count_q[i]);
                        2'd2: rd_mux = {16'b0, presc_q[i], 5'b0,
                                        ie_q[i], per_q[i], en_q[i]};
                        2'd3: rd_mux = {31'b0, pend_q[i]};
                    endcase
                end
            end
        end else if (off[7:2] == 6'd0) begin
            rd_mux = 32'(pend_q);
        end
`ifdef TIMER_FREE_RUN_EN
        else if (off[7:2] == 6'd1) begin
            rd_mux = frc_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rdata <= '0;
            sel       <= 1'b0;
        end else begin
            sel <= rd;
            if (rd)
                ram_rdata <= rd_mux;
        end
    end

    assign irq = |(pend_q & ie_q);

    logic unused_ok;
    assign unused_ok = ^{ram_addr[1:0], ld_new, ctl_new};

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed self-checking bench for mmio_timer_bank.
// Each task drives one scenario and checks its own results inline.
module tb_mmio_timer_bank;

    localparam logic [31:0] B = 32'hE0001000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_cen = 1'b0;
    logic        ram_wen = 1'b0;
    logic [3:0]  ram_flag = 4'h0;
    logic [31:0] ram_addr = 32'h0;
    logic [31:0] ram_wdata = 32'h0;
    logic [31:0] ram_rdata;
    logic        irq;
    logic        sel;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    mmio_timer_bank #(.N_CH(2), .CNT_W(32), .BASE_ADDR(B)) dut (
        .clk(clk), .rst(rst), .ram_cen(ram_cen), .ram_wen(ram_wen),
        .ram_flag(ram_flag), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .irq(irq), .sel(sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Access lands on the next posedge; returns #1 after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] f);
        @(negedge clk);
        ram_cen = 1'b1; ram_wen = 1'b1; ram_addr = B + a;
        ram_wdata = d; ram_flag = f;
        @(posedge clk); #1;
        ram_cen = 1'b0; ram_wen = 1'b0;
    endtask

    task automatic rdr(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = B + a;
        @(posedge clk); #1;
        d = ram_rdata;
        ram_cen = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] offs [6];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h18, 32'h100};
        #1;
        nchk++;
        if (ram_rdata !== 32'h0 || irq !== 1'b0 || sel !== 1'b0) begin
            nfail++;
            $display("FAIL reset_outs: rdata=%h irq=%b sel=%b want 0/0/0",
                     ram_rdata, irq, sel);
        end
        @(negedge clk); rst = 1'b0;
        foreach (offs[i]) begin
            rdr(offs[i], d);
            nchk++;
            if (d !== 32'h0) begin
                nfail++;
                $display("FAIL reset_reg[%h]: got %h want 0", offs[i], d);
            end
        end
        nchk++;
        if (sel !== 1'b1) begin
            nfail++;
            $display("FAIL sel_after_read: got %b want 1", sel);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        int e0;
        wr(32'h0, 32'd9999, 4'hF);
        wr(32'h8, 32'h7, 4'hF);
        e0 = cyc;
        wait_until(e0 + 9999);
        nchk++;
        if (irq !== 1'b0) begin
            nfail++;
            $display("FAIL periodic_early: irq=%b want 0", irq);
        end
        @(posedge clk); #1;
        nchk++;
        if (irq !== 1'b1) begin
            nfail++;
            $display("FAIL periodic_first: irq=%b want 1", irq);
        end
        wr(32'hC, 32'h1, 4'h1);
        nchk++;
        if (irq !== 1'b0) begin
            nfail++;
            $display("FAIL periodic_w1c: irq=%b want 0", irq);
        end
        wait_until(e0 + 19999);
        nchk++;
        if (irq !== 1'b0) begin
            nfail++;
            $display("FAIL periodic_second_early: irq=%b want 0", irq);
        end
        @(posedge clk); #1;
        nchk++;
        if (irq !== 1'b1) begin
            nfail++;
            $display("FAIL periodic_second: irq=%b want 1", irq);
        end
        wr(32'h8, 32'h0, 4'hF);
        wr(32'hC, 32'h1, 4'hF);
        rdr(32'hC, d);
        nchk++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            nfail++;
            $display("FAIL periodic_stop: status=%h irq=%b want 0/0", d, irq);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        int e0;
        wr(32'h10, 32'd3, 4'hF);
        wr(32'h18, 32'h0305, 4'hF);
        e0 = cyc;
        wait_until(e0 + 15);
        nchk++;
        if (irq !== 1'b0) begin
            nfail++;
            $display("FAIL oneshot_early: irq=%b want 0", irq);
        end
        @(posedge clk); #1;
        nchk++;
        if (irq !== 1'b1) begin
            nfail++;
            $display("FAIL oneshot_fire: irq=%b want 1", irq);
        end
        rdr(32'h18, d);
        nchk++;
        if (d !== 32'h0304) begin
            nfail++;
            $display("FAIL oneshot_ctrl: got %h want 00000304", d);
        end
        rdr(32'h14, d);
        nchk++;
        if (d !== 32'h0) begin
            nfail++;
            $display("FAIL oneshot_count: got %h want 0", d);
        end
        wr(32'h1C, 32'h1, 4'h1);
        repeat (40) @(posedge clk);
        #1;
        rdr(32'h1C, d);
        nchk++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            nfail++;
            $display("FAIL oneshot_repend: status=%h irq=%b want 0/0", d, irq);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        wr(32'h0, 32'h0, 4'hF);
        wr(32'h0, 32'hAABBCCDD, 4'b0010);
        rdr(32'h0, d);
        nchk++;
        if (d !== 32'h0000CC00) begin
            nfail++;
            $display("FAIL be_load: got %h want 0000CC00", d);
        end
        rdr(32'h4, d);
        nchk++;
        if (d !== 32'h0000CC00) begin
            nfail++;
            $display("FAIL be_count: got %h want 0000CC00", d);
        end
        wr(32'h20, 32'h12345678, 4'hF);
        rdr(32'h20, d);
        nchk++;
        if (d !== 32'h0) begin
            nfail++;
            $display("FAIL unmapped_ch2: got %h want 0", d);
        end
        rdr(32'h1F0, d);
        nchk++;
        if (d !== 32'h0) begin
            nfail++;
            $display("FAIL unmapped_1f0: got %h want 0", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int c;
        wr(32'h0, 32'h0, 4'hF);
        wr(32'h8, 32'h0303, 4'hF);
        c = cyc;
        wait_until(c + 7);
        wr(32'hC, 32'h1, 4'h1);
        rdr(32'hC, d);
        nchk++;
        if (d !== 32'h1) begin
            nfail++;
            $display("FAIL collision_w1c: status=%h want 1", d);
        end
        wr(32'hC, 32'h1, 4'h1);
        rdr(32'hC, d);
        nchk++;
        if (d !== 32'h0) begin
            nfail++;
            $display("FAIL offcycle_w1c: status=%h want 0", d);
        end
        wait_until(c + 12);
        rdr(32'h100, d);
        nchk++;
        if (d !== 32'h1) begin
            nfail++;
            $display("FAIL irq_stat: got %h want 1", d);
        end
        wr(32'hC, 32'h1, 4'h0);
        rdr(32'hC, d);
        nchk++;
        if (d !== 32'h1) begin
            nfail++;
            $display("FAIL w1c_no_flag: status=%h want 1", d);
        end
        wr(32'h8, 32'h0, 4'hF);
        wr(32'hC, 32'h1, 4'h1);
    endtask

    task automatic test_free_run();
        logic [31:0] d0;
        logic [31:0] d1;
`ifdef TIMER_FREE_RUN_EN
        rdr(32'h104, d0);
        repeat (4) @(posedge clk);
        rdr(32'h104, d1);
        nchk++;
        if (d1 - d0 !== 32'd5) begin
            nfail++;
            $display("FAIL frc_delta: got %0d want 5", d1 - d0);
        end
        wr(32'h104, 32'h0, 4'hF);
        rdr(32'h104, d1);
        nchk++;
        if (d1 > 32'd2) begin
            nfail++;
            $display("FAIL frc_clear: got %0d want <=2", d1);
        end
`else
        rdr(32'h104, d0);
        repeat (4) @(posedge clk);
        rdr(32'h104, d1);
        nchk++;
        if (d0 !== 32'h0 || d1 !== 32'h0) begin
            nfail++;
            $display("FAIL frc_absent: got %h/%h want 0/0", d0, d1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(32'h10, 32'h0, 4'hF);
        wr(32'h18, 32'h7, 4'hF);
        rdr(32'h18, d);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        nchk++;
        if (ram_rdata !== 32'h0 || irq !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid: rdata=%h irq=%b want 0/0 (pre %h)",
                     ram_rdata, irq, d);
        end
        @(negedge clk); rst = 1'b0;
        rdr(32'h18, d);
        nchk++;
        if (d !== 32'h0) begin
            nfail++;
            $display("FAIL reset_mid_ctrl: got %h want 0", d);
        end
        rdr(32'h100, d);
        nchk++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid_pend: got %h irq=%b want 0/0", d, irq);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_byte_enable();
        test_collision();
        test_free_run();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
